// File: rtl/alu_sequencer_if.sv
// Control bundle between the ALU sequencer and its datapath: run/memory handshake
// and instruction in, bus-driver and load strobes out.
interface alu_sequencer_if;
  logic        Run;
  logic        MemReady;
  logic [31:0] IR;
  logic        PCout;
  logic        Zlowout;
  logic        MDRout;
  logic        MARin;
  logic        PCin;
  logic        MDRin;
  logic        IRin;
  logic        Yin;
  logic        Zin;
  logic        IncPC;
  logic        Read;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic [4:0]  AluOp;
  logic        Busy;
  logic        Halted;

  modport master (
    input  Run, MemReady, IR,
    output PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
    output Gra, Grb, Grc, Rin, Rout, AluOp, Busy, Halted
  );

  modport slave (
    output Run, MemReady, IR,
    input  PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
    input  Gra, Grb, Grc, Rin, Rout, AluOp, Busy, Halted
  );
endinterface

// File: rtl/alu_sequencer.sv
// Moore control sequencer for a single-bus datapath: fetch (T0..T2) then
// three-step register ALU execute (T3..T5), with halt and nop opcodes.
module alu_sequencer (
  input  logic           Clock,
  input  logic           Clear,
  alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobes_t;

  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_r;
  state_t     state_next_s;
  strobes_t   ctl_r;
  strobes_t   ctl_next_s;
  logic [4:0] alu_op_r;
  logic [4:0] alu_op_next_s;
  logic       busy_r;
  logic       busy_next_s;
  logic       halted_r;
  logic       halted_next_s;
  logic [4:0] opcode_s;

  assign opcode_s = bus.IR[31:27];

  // Opcodes 00000..00111 are the register-to-register ALU instructions.
  function automatic logic is_alu_op(input logic [4:0] op);
    is_alu_op = (op[4:3] == 2'b00);
  endfunction

  // Next-state selection; Run is only consulted at instruction boundaries.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: state_next_s = bus.Run ? T0 : IDLE;
      T0:   state_next_s = T1;
      T1:   state_next_s = bus.MemReady ? T2 : T1;
      T2: begin
        if (is_alu_op(opcode_s)) begin
          state_next_s = T3;
        end else if (opcode_s == OP_HALT) begin
          state_next_s = HALT;
        end else begin
          state_next_s = bus.Run ? T0 : IDLE;
        end
      end
      T3:      state_next_s = T4;
      T4:      state_next_s = T5;
      T5:      state_next_s = bus.Run ? T0 : IDLE;
      HALT:    state_next_s = HALT;
      default: state_next_s = IDLE;
    endcase
  end

  // Decode of the state being entered, so the registered strobes line up with it.
  always_comb begin
    ctl_next_s    = '0;
    alu_op_next_s = 5'b00000;
    busy_next_s   = 1'b0;
    halted_next_s = 1'b0;
    case (state_next_s)
      IDLE: begin
        busy_next_s = 1'b0;
      end
      T0: begin
        ctl_next_s.pc_out = 1'b1;
        ctl_next_s.mar_in = 1'b1;
        ctl_next_s.inc_pc = 1'b1;
        ctl_next_s.z_in   = 1'b1;
        busy_next_s       = 1'b1;
      end
      T1: begin
        ctl_next_s.zlow_out = 1'b1;
        // PC loads only on T1 entry so memory wait cycles never re-increment it.
        ctl_next_s.pc_in    = (state_r != T1);
        ctl_next_s.read     = 1'b1;
        ctl_next_s.mdr_in   = 1'b1;
        busy_next_s         = 1'b1;
      end
      T2: begin
        ctl_next_s.mdr_out = 1'b1;
        ctl_next_s.ir_in   = 1'b1;
        busy_next_s        = 1'b1;
      end
      T3: begin
        ctl_next_s.grb   = 1'b1;
        ctl_next_s.r_out = 1'b1;
        ctl_next_s.y_in  = 1'b1;
        busy_next_s      = 1'b1;
      end
      T4: begin
        ctl_next_s.grc   = 1'b1;
        ctl_next_s.r_out = 1'b1;
        ctl_next_s.z_in  = 1'b1;
        alu_op_next_s    = opcode_s;
        busy_next_s      = 1'b1;
      end
      T5: begin
        ctl_next_s.zlow_out = 1'b1;
        ctl_next_s.gra      = 1'b1;
        ctl_next_s.r_in     = 1'b1;
        busy_next_s         = 1'b1;
      end
      HALT: begin
        halted_next_s = 1'b1;
      end
      default: begin
        busy_next_s = 1'b0;
      end
    endcase
  end

  // State and output registers; Clear drops everything to IDLE immediately.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_r  <= IDLE;
      ctl_r    <= '0;
      alu_op_r <= 5'b00000;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      ctl_r    <= ctl_next_s;
      alu_op_r <= alu_op_next_s;
      busy_r   <= busy_next_s;
      halted_r <= halted_next_s;
    end
  end

  assign bus.PCout   = ctl_r.pc_out;
  assign bus.Zlowout = ctl_r.zlow_out;
  assign bus.MDRout  = ctl_r.mdr_out;
  assign bus.MARin   = ctl_r.mar_in;
  assign bus.PCin    = ctl_r.pc_in;
  assign bus.MDRin   = ctl_r.mdr_in;
  assign bus.IRin    = ctl_r.ir_in;
  assign bus.Yin     = ctl_r.y_in;
  assign bus.Zin     = ctl_r.z_in;
  assign bus.IncPC   = ctl_r.inc_pc;
  assign bus.Read    = ctl_r.read;
  assign bus.Gra     = ctl_r.gra;
  assign bus.Grb     = ctl_r.grb;
  assign bus.Grc     = ctl_r.grc;
  assign bus.Rin     = ctl_r.r_in;
  assign bus.Rout    = ctl_r.r_out;
  assign bus.AluOp   = alu_op_r;
  assign bus.Busy    = busy_r;
  assign bus.Halted  = halted_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer: expected output vectors are queued
// per step from a reference decode table and popped when the DUT is sampled.
module tb_alu_sequencer;

  localparam int S_IDLE = 0;
  localparam int S_T0   = 1;
  localparam int S_T1   = 2;
  localparam int S_T2   = 3;
  localparam int S_T3   = 4;
  localparam int S_T4   = 5;
  localparam int S_T5   = 6;
  localparam int S_HALT = 7;

  logic Clock = 1'b0;
  logic Clear;
  int   checks = 0;
  int   errors = 0;
  logic [22:0] exp_q[$];
  string       tag_q[$];

  alu_sequencer_if bus();

  alu_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Vector order: PCout Zlowout MDRout MARin PCin MDRin IRin Yin Zin IncPC Read
  //               Gra Grb Grc Rin Rout | AluOp[4:0] | Busy | Halted
  function automatic logic [22:0] model(input int st, input logic first, input logic [4:0] op);
    logic [15:0] s;
    logic [4:0]  a;
    logic        b;
    logic        h;
    s = 16'h0000;
    a = 5'b00000;
    b = 1'b0;
    h = 1'b0;
    case (st)
      S_T0:   begin s[15] = 1'b1; s[12] = 1'b1; s[6] = 1'b1; s[7] = 1'b1; b = 1'b1; end
      S_T1:   begin s[14] = 1'b1; s[11] = first; s[5] = 1'b1; s[10] = 1'b1; b = 1'b1; end
      S_T2:   begin s[13] = 1'b1; s[9] = 1'b1; b = 1'b1; end
      S_T3:   begin s[3] = 1'b1; s[0] = 1'b1; s[8] = 1'b1; b = 1'b1; end
      S_T4:   begin s[2] = 1'b1; s[0] = 1'b1; s[7] = 1'b1; a = op; b = 1'b1; end
      S_T5:   begin s[14] = 1'b1; s[4] = 1'b1; s[1] = 1'b1; b = 1'b1; end
      S_HALT: begin h = 1'b1; end
      default: begin s = 16'h0000; end
    endcase
    return {s, a, b, h};
  endfunction

  function automatic logic [22:0] observed();
    return {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.PCin, bus.MDRin,
            bus.IRin, bus.Yin, bus.Zin, bus.IncPC, bus.Read,
            bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
            bus.AluOp, bus.Busy, bus.Halted};
  endfunction

  task automatic expect_state(input int st, input logic first, input logic [4:0] op, input string tag);
    exp_q.push_back(model(st, first, op));
    tag_q.push_back(tag);
  endtask

  task automatic compare_now();
    logic [22:0] e;
    logic [22:0] o;
    string       t;
    int          drivers;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue, required a pending entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = observed();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", t, o, e);
      end
      drivers = $countones({bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout});
      checks++;
      assert (drivers <= 1) else begin
        errors++;
        $error("FAIL %s_bus_driver: observed %0d drivers required <=1", t, drivers);
      end
    end
  endtask

  task automatic step(input int st, input logic first, input logic [4:0] op, input string tag);
    expect_state(st, first, op, tag);
    @(posedge Clock);
    #1;
    compare_now();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Clear        = 1'b0;
    bus.Run      = 1'b0;
    bus.MemReady = 1'b1;
    bus.IR       = 32'h00000000;
    repeat (2) @(posedge Clock);
    #1;
    expect_state(S_IDLE, 1'b0, 5'b00000, "reset");
    compare_now();
    Clear = 1'b1;
    step(S_IDLE, 1'b0, 5'b00000, "idle_hold");

    // shl R5,R2,R4 with memory always ready
    bus.Run = 1'b1;
    bus.IR  = 32'h1A920000;
    step(S_T0, 1'b0, 5'b00000, "shl_t0");
    step(S_T1, 1'b1, 5'b00000, "shl_t1");
    step(S_T2, 1'b0, 5'b00000, "shl_t2");
    step(S_T3, 1'b0, 5'b00000, "shl_t3");
    step(S_T4, 1'b0, 5'b00011, "shl_t4");
    step(S_T5, 1'b0, 5'b00000, "shl_t5");
    step(S_T0, 1'b0, 5'b00000, "shl_next_t0");

    // memory wait for three edges in T1, then a nop instruction
    bus.MemReady = 1'b0;
    bus.IR       = 32'hF8000000;
    step(S_T1, 1'b1, 5'b00000, "wait_t1_c1");
    step(S_T1, 1'b0, 5'b00000, "wait_t1_c2");
    step(S_T1, 1'b0, 5'b00000, "wait_t1_c3");
    step(S_T1, 1'b0, 5'b00000, "wait_t1_c4");
    bus.MemReady = 1'b1;
    step(S_T2, 1'b0, 5'b00000, "wait_t2");
    step(S_T0, 1'b0, 5'b00000, "nop_t0");

    // halt instruction holds until Clear
    bus.IR = 32'hD8000000;
    step(S_T1, 1'b1, 5'b00000, "halt_t1");
    step(S_T2, 1'b0, 5'b00000, "halt_t2");
    step(S_HALT, 1'b0, 5'b00000, "halt_enter");
    for (int i = 0; i < 10; i++) begin
      bus.MemReady = ~bus.MemReady;
      step(S_HALT, 1'b0, 5'b00000, "halt_hold");
    end
    #3;
    Clear = 1'b0;
    #1;
    expect_state(S_IDLE, 1'b0, 5'b00000, "halt_clear");
    compare_now();

    // Clear between edges while in T4
    @(negedge Clock);
    Clear        = 1'b1;
    bus.MemReady = 1'b1;
    bus.IR       = 32'h00000000;
    bus.Run      = 1'b1;
    step(S_T0, 1'b0, 5'b00000, "clr_t0");
    step(S_T1, 1'b1, 5'b00000, "clr_t1");
    step(S_T2, 1'b0, 5'b00000, "clr_t2");
    step(S_T3, 1'b0, 5'b00000, "clr_t3");
    step(S_T4, 1'b0, 5'b00000, "clr_t4");
    #2;
    Clear = 1'b0;
    #1;
    expect_state(S_IDLE, 1'b0, 5'b00000, "clear_mid_t4");
    compare_now();

    // Run dropped during T3 does not abort the add
    @(negedge Clock);
    Clear = 1'b1;
    step(S_T0, 1'b0, 5'b00000, "drop_t0");
    step(S_T1, 1'b1, 5'b00000, "drop_t1");
    step(S_T2, 1'b0, 5'b00000, "drop_t2");
    step(S_T3, 1'b0, 5'b00000, "drop_t3");
    bus.Run = 1'b0;
    step(S_T4, 1'b0, 5'b00000, "drop_t4");
    step(S_T5, 1'b0, 5'b00000, "drop_t5");
    step(S_IDLE, 1'b0, 5'b00000, "drop_idle");
    step(S_IDLE, 1'b0, 5'b00000, "drop_idle_hold");

    // Clear while waiting on memory in T1
    bus.Run      = 1'b1;
    bus.MemReady = 1'b0;
    step(S_T0, 1'b0, 5'b00000, "wclr_t0");
    step(S_T1, 1'b1, 5'b00000, "wclr_t1_c1");
    step(S_T1, 1'b0, 5'b00000, "wclr_t1_c2");
    #3;
    Clear = 1'b0;
    #1;
    expect_state(S_IDLE, 1'b0, 5'b00000, "clear_t1_wait");
    compare_now();
    @(negedge Clock);
    Clear        = 1'b1;
    bus.Run      = 1'b0;
    bus.MemReady = 1'b1;
    step(S_IDLE, 1'b0, 5'b00000, "post_clear_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
